tft_rx_timing: RTL and testbench

- Receive-side counterpart of the TFT timing generator: consumes a parallel RGB/DE/HS/VS stream on the pixel clock.
- Recovers per-pixel X/Y coordinates and measures frame geometry (active width/height, horizontal total).
- Declares lock once the geometry is stable.
- Used for loopback checking of the TFT output path and as the front end of a capture/overlay path.

---
 rtl/tft_rx_pkg.sv | 20 ++
 rtl/tft_sync_edge.sv | 39 +++
 rtl/tft_rx_timing.sv | 241 ++++++++++++++++++++++++
 tb/tb_tft_rx_timing.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tft_rx_pkg.sv
// Shared definitions for the TFT receive-timing block.
//
// Contents:
//   lock_state_t       : states of the geometry lock FSM
//   H_ACTIVE/V_ACTIVE  : reference 800x480 panel active area
//   H_TOTAL/V_TOTAL    : reference 800x480 panel totals (clocks per line, lines per frame)
package tft_rx_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_SEARCH,
    ST_LOCKED
  } lock_state_t;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 1056;
  localparam int V_TOTAL  = 525;

endpackage

// File: rtl/tft_sync_edge.sv
// Input register plus edge detector for one TFT control signal.
// The raw input is normalised so that 'level' is 1 when the signal is at
// its active level, which lets the same block serve DE, HS and VS.
//
// Ports:
//   clk   : pixel clock
//   rst   : asynchronous active-high reset (register goes to inactive level)
//   raw   : unregistered input signal
//   level : registered, polarity-normalised signal (1 = active)
//   lead  : one-cycle pulse on the inactive-to-active transition of level
//   trail : one-cycle pulse on the active-to-inactive transition of level
module tft_sync_edge #(
  parameter logic ACT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic lead,
  output logic trail
);

  logic prev;

  // Normalised input register and its one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      level <= (raw == ACT);
      prev  <= level;
    end
  end

  assign lead  = level & ~prev;
  assign trail = ~level & prev;

endmodule

// File: rtl/tft_rx_timing.sv
// Receive-side TFT timing recovery. Consumes RGB/DE/HS/VS on the pixel
// clock, recovers per-pixel X/Y coordinates, measures frame geometry and
// reports lock once the geometry repeats for LOCK_FRAMES frames.
// Stage 1 registers the inputs, stage 2 registers every output, giving a
// fixed two-clock latency from an input pixel to its pix_* outputs.
//
// Ports:
//   tft_clk, sys_rst          : pixel clock, asynchronous active-high reset
//   tft_de/hs/vs/rgb          : incoming video stream
//   pix_valid/x/y/data        : registered pixel with its coordinates
//   line_start, frame_start   : pulses with first pixel of a line / of a frame
//   act_width, act_height     : last measured active geometry
//   h_total                   : last measured clocks between HS leading edges
//   locked, timing_err        : geometry-stable flag, error pulse
module tft_rx_timing
  import tft_rx_pkg::*;
#(
  parameter int   H_BITS      = 11,
  parameter int   V_BITS      = 11,
  parameter int   T_BITS      = 12,
  parameter logic HS_ACT      = 1'b0,
  parameter logic VS_ACT      = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic              tft_clk,
  input  logic              sys_rst,
  input  logic              tft_de,
  input  logic              tft_hs,
  input  logic              tft_vs,
  input  logic [23:0]       tft_rgb,
  output logic              pix_valid,
  output logic [H_BITS-1:0] pix_x,
  output logic [V_BITS-1:0] pix_y,
  output logic [23:0]       pix_data,
  output logic              line_start,
  output logic              frame_start,
  output logic [H_BITS-1:0] act_width,
  output logic [V_BITS-1:0] act_height,
  output logic [T_BITS-1:0] h_total,
  output logic              locked,
  output logic              timing_err
);

  localparam logic [H_BITS-1:0] X_MAX  = '1;
  localparam logic [V_BITS-1:0] Y_MAX  = '1;
  localparam logic [T_BITS-1:0] T_MAX  = '1;
  localparam logic [H_BITS-1:0] H_ONE  = H_BITS'(1);
  localparam logic [V_BITS-1:0] V_ONE  = V_BITS'(1);
  localparam logic [T_BITS-1:0] T_ONE  = T_BITS'(1);
  localparam logic [3:0]        LOCK_N = 4'(LOCK_FRAMES);

  logic de_q, de_rise, de_fall;
  logic hs_q, hs_lead, hs_trail;
  logic vs_q, vs_lead, vs_trail;
  logic unused_edges;
  logic [23:0] rgb_q;

  logic [H_BITS-1:0] x_last;
  logic              x_sat_flag;
  logic [V_BITS-1:0] y_cnt;
  logic              line_seen;
  logic              frame_pend;
  logic [T_BITS-1:0] h_cnt;
  logic              h_seen;

  lock_state_t       state;
  logic [3:0]        match_cnt;
  logic [H_BITS-1:0] snap_w;
  logic [V_BITS-1:0] snap_h;
  logic [T_BITS-1:0] snap_t;

  logic [H_BITS-1:0] x_col, width_new, act_width_nx;
  logic [V_BITS-1:0] y_inc, act_height_nx;
  logic [T_BITS-1:0] h_total_nx;
  logic              x_sat_evt, y_sat_evt, width_err, lock_break, tuple_eq;

  tft_sync_edge #(.ACT(1'b1))   u_de (.clk(tft_clk), .rst(sys_rst), .raw(tft_de),
                                      .level(de_q), .lead(de_rise), .trail(de_fall));
  tft_sync_edge #(.ACT(HS_ACT)) u_hs (.clk(tft_clk), .rst(sys_rst), .raw(tft_hs),
                                      .level(hs_q), .lead(hs_lead), .trail(hs_trail));
  tft_sync_edge #(.ACT(VS_ACT)) u_vs (.clk(tft_clk), .rst(sys_rst), .raw(tft_vs),
                                      .level(vs_q), .lead(vs_lead), .trail(vs_trail));

  // Only leading edges of the sync signals are used.
  assign unused_edges = hs_q ^ hs_trail ^ vs_q ^ vs_trail;

  // Next-state values for counters and measurements. A VS leading edge in the
  // same cycle as a DE falling edge sees the incremented Y, so act_height
  // includes that line; the lock comparison also uses these updated values.
  always_comb begin
    x_col         = '0;
    width_new     = (x_last == X_MAX) ? X_MAX : x_last + H_ONE;
    y_inc         = y_cnt;
    act_width_nx  = act_width;
    act_height_nx = act_height;
    h_total_nx    = h_total;
    if (!de_rise)
      x_col = (x_last == X_MAX) ? X_MAX : x_last + H_ONE;
    if (de_fall)
      y_inc = (y_cnt == Y_MAX) ? Y_MAX : y_cnt + V_ONE;
    if (de_fall)
      act_width_nx = width_new;
    if (vs_lead && (y_inc != '0))
      act_height_nx = y_inc;
    if (hs_lead && h_seen)
      h_total_nx = h_cnt;
    x_sat_evt  = de_q & ~de_rise & (x_last == X_MAX) & ~x_sat_flag;
    y_sat_evt  = de_fall & (y_cnt == Y_MAX);
    width_err  = de_fall & line_seen & (width_new != act_width);
    lock_break = width_err | x_sat_evt | y_sat_evt;
    tuple_eq   = (act_width_nx == snap_w) && (act_height_nx == snap_h) &&
                 (h_total_nx == snap_t);
  end

  // Coordinate counters, geometry measurement and the registered pixel outputs.
  always_ff @(posedge tft_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rgb_q       <= '0;
      x_last      <= '0;
      x_sat_flag  <= 1'b0;
      y_cnt       <= '0;
      line_seen   <= 1'b0;
      frame_pend  <= 1'b0;
      h_cnt       <= '0;
      h_seen      <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      act_width   <= '0;
      act_height  <= '0;
      h_total     <= '0;
    end else begin
      rgb_q <= tft_rgb;
      if (de_q)
        x_last <= x_col;
      if (de_rise)
        x_sat_flag <= 1'b0;
      else if (x_sat_evt)
        x_sat_flag <= 1'b1;
      if (vs_lead)
        y_cnt <= '0;
      else if (de_fall)
        y_cnt <= y_inc;
      if (vs_lead)
        line_seen <= 1'b0;
      else if (de_fall)
        line_seen <= 1'b1;
      if (de_rise)
        frame_pend <= 1'b0;
      else if (vs_lead)
        frame_pend <= 1'b1;
      // h_cnt equals the HS period at the next leading edge; the very first
      // edge after reset only arms the measurement.
      if (hs_lead)
        h_cnt <= T_ONE;
      else if (h_cnt != T_MAX)
        h_cnt <= h_cnt + T_ONE;
      if (hs_lead)
        h_seen <= 1'b1;
      pix_valid   <= de_q;
      pix_x       <= de_q ? x_col : '0;
      pix_y       <= y_cnt;
      pix_data    <= rgb_q;
      line_start  <= de_rise;
      frame_start <= de_rise & (frame_pend | vs_lead);
      act_width   <= act_width_nx;
      act_height  <= act_height_nx;
      h_total     <= h_total_nx;
    end
  end

  // Lock FSM. Geometry is compared at each VS leading edge; a mismatch resets
  // the match count and reloads the snapshot so a new stable geometry can lock.
  always_ff @(posedge tft_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ST_UNLOCKED;
      match_cnt  <= '0;
      snap_w     <= '0;
      snap_h     <= '0;
      snap_t     <= '0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      timing_err <= lock_break | ((state == ST_LOCKED) & vs_lead & ~tuple_eq);
      case (state)
        ST_UNLOCKED: begin
          locked <= 1'b0;
          if (vs_lead) begin
            state     <= ST_SEARCH;
            match_cnt <= '0;
            snap_w    <= '0;
            snap_h    <= '0;
            snap_t    <= '0;
          end
        end
        ST_SEARCH: begin
          locked <= 1'b0;
          if (vs_lead) begin
            if (tuple_eq && !lock_break) begin
              match_cnt <= match_cnt + 4'd1;
              if (match_cnt + 4'd1 >= LOCK_N) begin
                state  <= ST_LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match_cnt <= '0;
              snap_w    <= act_width_nx;
              snap_h    <= act_height_nx;
              snap_t    <= h_total_nx;
            end
          end else if (lock_break) begin
            match_cnt <= '0;
          end
        end
        ST_LOCKED: begin
          locked <= 1'b1;
          if (vs_lead && !tuple_eq) begin
            state     <= ST_SEARCH;
            locked    <= 1'b0;
            match_cnt <= '0;
            snap_w    <= act_width_nx;
            snap_h    <= act_height_nx;
            snap_t    <= h_total_nx;
          end else if (lock_break) begin
            state     <= ST_SEARCH;
            locked    <= 1'b0;
            match_cnt <= '0;
          end
        end
        default: begin
          state  <= ST_UNLOCKED;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tft_rx_timing.sv
// Self-checking bench for tft_rx_timing. Uses a scaled-down raster
// (20 active pixels of a 28-clock line, 8 or 7 active lines) so the whole
// lock/unlock/relock sequence stays short; the long-DE line still exercises
// the full 11-bit X saturation.
module tb_tft_rx_timing;

  localparam int   W      = 20;
  localparam int   HT     = 28;
  localparam int   HS_W   = 3;
  localparam int   H_BP   = 5;
  localparam int   VS_L   = 2;
  localparam int   ACT_L0 = 3;
  localparam int   LOCK   = 2;
  localparam logic HS_ACT = 1'b0;
  localparam logic VS_ACT = 1'b0;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [23:0] rgb;
    logic        ls;
    logic        fs;
    logic [15:0] cyc;
  } pix_t;

  logic        tft_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        tft_de  = 1'b0;
  logic        tft_hs  = ~HS_ACT;
  logic        tft_vs  = ~VS_ACT;
  logic [23:0] tft_rgb = '0;
  logic        pix_valid, line_start, frame_start, locked, timing_err;
  logic [10:0] pix_x, pix_y, act_width, act_height;
  logic [23:0] pix_data;
  logic [11:0] h_total;

  pix_t sb[$];
  pix_t mon_e;
  int   checks    = 0;
  int   failures  = 0;
  int   err_count = 0;
  int   cyc       = 0;
  int   exp_err   = 0;

  tft_rx_timing #(
    .H_BITS(11), .V_BITS(11), .T_BITS(12),
    .HS_ACT(HS_ACT), .VS_ACT(VS_ACT), .LOCK_FRAMES(LOCK)
  ) dut (
    .tft_clk(tft_clk), .sys_rst(sys_rst), .tft_de(tft_de), .tft_hs(tft_hs),
    .tft_vs(tft_vs), .tft_rgb(tft_rgb), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_data(pix_data), .line_start(line_start),
    .frame_start(frame_start), .act_width(act_width), .act_height(act_height),
    .h_total(h_total), .locked(locked), .timing_err(timing_err)
  );

  always #15 tft_clk = ~tft_clk;

  always @(posedge tft_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer and error-pulse counter, sampled on the falling edge.
  always @(negedge tft_clk) begin
    if (!sys_rst) begin
      if (timing_err)
        err_count++;
      if (pix_valid) begin
        if (sb.size() == 0) begin
          checkOutput("pix_extra", 128'(pix_valid), 128'(0));
        end else begin
          mon_e = sb.pop_front();
          checkOutput("pix", 128'({pix_x, pix_y, pix_data, line_start, frame_start, 16'(cyc)}),
                      128'(mon_e));
        end
      end
    end
  end

  // Drives one clock of stimulus and records the pixel the DUT must emit two clocks later.
  task automatic applyStimulus(input logic de, input logic hs, input logic vs,
                               input logic [23:0] rgb, input int ex, input int ey);
    pix_t p;
    @(posedge tft_clk);
    #1;
    tft_de  = de;
    tft_hs  = hs ? HS_ACT : ~HS_ACT;
    tft_vs  = vs ? VS_ACT : ~VS_ACT;
    tft_rgb = rgb;
    if (de) begin
      p.x   = 11'((ex > 2047) ? 2047 : ex);
      p.y   = 11'(ey);
      p.rgb = rgb;
      p.ls  = (ex == 0);
      p.fs  = (ex == 0) && (ey == 0);
      p.cyc = 16'(cyc + 2);
      sb.push_back(p);
    end
  endtask

  // One frame: VS for 2 lines, active lines from line 3, one trailing blank line.
  // lastW sets the width of the final active line; longDe > 0 replaces the
  // active area with a single DE pulse of that many clocks; stopAt >= 0 aborts.
  task automatic driveFrame(input int nLines, input int lastW, input int longDe, input int stopAt);
    int total, c, ex, ey;
    logic de;
    logic [23:0] rgb;
    total = ACT_L0 + nLines + 1;
    for (int l = 0; l < total; l++) begin
      for (int h = 0; h < HT; h++) begin
        c = l * HT + h;
        if (stopAt >= 0 && c == stopAt)
          return;
        if (longDe > 0) begin
          ex = c - (ACT_L0 * HT + H_BP);
          ey = 0;
          de = (ex >= 0) && (ex < longDe);
        end else begin
          ex = h - H_BP;
          ey = l - ACT_L0;
          de = (l >= ACT_L0) && (l < ACT_L0 + nLines) && (ex >= 0) &&
               (ex < ((l == ACT_L0 + nLines - 1) ? lastW : W));
        end
        rgb = (ex == 5 && ey == 7) ? 24'h12AB34 : 24'($urandom);
        applyStimulus(de, h < HS_W, l < VS_L, rgb, ex, ey);
      end
    end
  endtask

  task automatic checkFrame(input int f, input logic expLocked, input int expW,
                            input int expH, input int expT, input int expErr);
    checkOutput($sformatf("locked_f%0d", f), 128'(locked), 128'(expLocked));
    checkOutput($sformatf("width_f%0d", f), 128'(act_width), 128'(expW));
    checkOutput($sformatf("height_f%0d", f), 128'(act_height), 128'(expH));
    checkOutput($sformatf("htotal_f%0d", f), 128'(h_total), 128'(expT));
    checkOutput($sformatf("errs_f%0d", f), 128'(err_count), 128'(expErr));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pix"}, 128'({pix_valid, pix_x, pix_y, pix_data, line_start, frame_start}), 128'(0));
    checkOutput({tag, "_geom"}, 128'({act_width, act_height, h_total}), 128'(0));
    checkOutput({tag, "_stat"}, 128'({locked, timing_err}), 128'(0));
  endtask

  initial begin
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
    checkResetState("rst_init");
    sys_rst = 1'b0;

    // Stable 8-line frames: lock at the VS starting frame 1+LOCK.
    for (int f = 0; f <= 4; f++) begin
      driveFrame(8, W, 0, -1);
      checkFrame(f, f >= 1 + LOCK, W, (f >= 1) ? 8 : 0, HT, 0);
    end

    // 7-line frames: mismatch reported at the VS ending frame 5, relock two frames later.
    for (int f = 5; f <= 8; f++) begin
      driveFrame(7, W, 0, -1);
      exp_err = (f >= 6) ? 1 : 0;
      checkFrame(f, (f == 5) || (f == 8), W, (f >= 6) ? 7 : 8, HT, exp_err);
    end

    // DE held for 2100 clocks while locked: X saturates at 2047.
    driveFrame(76, W, 2100, -1);
    checkFrame(9, 1'b0, 2047, 7, HT, 2);

    for (int f = 10; f <= 13; f++) begin
      driveFrame(8, W, 0, -1);
      checkFrame(f, f == 13, W, (f == 10) ? 1 : 8, HT, 2);
    end

    // One line one pixel wider inside a locked frame.
    driveFrame(8, W + 1, 0, -1);
    checkFrame(14, 1'b0, W + 1, 8, HT, 3);

    // Reset in the middle of a line, checked before the next clock edge.
    driveFrame(8, W, 0, ACT_L0 * HT + H_BP + 10);
    #2;
    sys_rst = 1'b1;
    #1;
    checkResetState("rst_async");
    sb.delete();
    tft_de = 1'b0;
    tft_hs = ~HS_ACT;
    tft_vs = ~VS_ACT;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
    sys_rst = 1'b0;

    driveFrame(8, W, 0, -1);
    checkFrame(16, 1'b0, W, 0, HT, 3);

    checkOutput("sb_drained", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
